// File: rtl/microproc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : microproc_pkg
// Description : Shared opcode values, IR field positions and the fetch-unit
//               state encoding for the microprocessor datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package microproc_pkg;

  // Opcode values carried in IR[31:24]
  localparam logic [7:0] SUB          = 8'h0A;
  localparam logic [7:0] MULT         = 8'h1A;
  localparam logic [7:0] RRS          = 8'h21;
  localparam logic [7:0] NANDOP       = 8'h22;
  localparam logic [7:0] OROP         = 8'h23;
  localparam logic [7:0] BRANCHIFZERO = 8'h14;

  // IR field bit positions: {OPCODE, -, R1, R2, R3, IMM}
  localparam int IR_OP_MSB  = 31;
  localparam int IR_OP_LSB  = 24;
  localparam int IR_R1_MSB  = 22;
  localparam int IR_R1_LSB  = 18;
  localparam int IR_R2_MSB  = 17;
  localparam int IR_R2_LSB  = 13;
  localparam int IR_R3_MSB  = 12;
  localparam int IR_R3_LSB  = 8;
  localparam int IR_IMM_MSB = 7;
  localparam int IR_IMM_LSB = 0;

  // Fetch-unit sequencing states
  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } ifu_state_e;

  // Extracts the opcode field of an instruction word
  function automatic logic [7:0] ir_opcode(input logic [31:0] word);
    return word[IR_OP_MSB:IR_OP_LSB];
  endfunction

endpackage : microproc_pkg
`default_nettype wire

// File: rtl/ifu_queue.sv
`default_nettype none
// ============================================================================
// Module      : ifu_queue
// Description : Two-entry FIFO of {pc, instruction} pairs. Entry 0 is the
//               head and drives the outputs directly from flops. Flush only
//               clears the occupancy so the head outputs hold their value.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_queue
  import microproc_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [31:0]       push_ir,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_pc,
  output logic [31:0]       head_ir,
  output logic [1:0]        count
);

  logic [ADDR_W-1:0] e0_pc_q, e0_pc_d, e1_pc_q, e1_pc_d;
  logic [31:0]       e0_ir_q, e0_ir_d, e1_ir_q, e1_ir_d;
  logic [1:0]        count_q, count_d;
  logic              pop_eff, push_eff;
  logic [1:0]        kept;

  // Next entry contents: shift on pop, then write the push into the first free slot
  always_comb begin
    e0_pc_d  = e0_pc_q;
    e0_ir_d  = e0_ir_q;
    e1_pc_d  = e1_pc_q;
    e1_ir_d  = e1_ir_q;
    count_d  = count_q;
    pop_eff  = pop && (count_q != 2'd0);
    push_eff = push && ((count_q != 2'd2) || pop_eff);
    kept     = count_q - {1'b0, pop_eff};
    if (flush) begin
      count_d = 2'd0;
    end else begin
      if (pop_eff && (count_q == 2'd2)) begin
        e0_pc_d = e1_pc_q;
        e0_ir_d = e1_ir_q;
      end
      if (push_eff) begin
        if (kept == 2'd0) begin
          e0_pc_d = push_pc;
          e0_ir_d = push_ir;
        end else begin
          e1_pc_d = push_pc;
          e1_ir_d = push_ir;
        end
      end
      count_d = kept + {1'b0, push_eff};
    end
  end

  // Entry and occupancy registers
  always_ff @(posedge clk) begin
    if (reset) begin
      e0_pc_q <= '0;
      e0_ir_q <= '0;
      e1_pc_q <= '0;
      e1_ir_q <= '0;
      count_q <= 2'd0;
    end else begin
      e0_pc_q <= e0_pc_d;
      e0_ir_q <= e0_ir_d;
      e1_pc_q <= e1_pc_d;
      e1_ir_q <= e1_ir_d;
      count_q <= count_d;
    end
  end

  assign head_pc = e0_pc_q;
  assign head_ir = e0_ir_q;
  assign count   = count_q;

endmodule : ifu_queue
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Instruction fetch front end. Owns the fetch PC and a
//               synchronous-read program ROM, buffers fetched words in a
//               two-entry queue and presents the head to control under a
//               valid/ready handshake. Handles BRANCHIFZERO redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
  import microproc_pkg::*;
#(
  parameter int    ADDR_W   = 8,
  parameter string INIT_HEX = ""
) (
  input  logic              clk,
  input  logic              reset,
  output logic [31:0]       ir,
  output logic [31:0]       ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              branch_load,
  input  logic [8:0]        branch_offset,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_data,
  output logic [31:0]       fetch_pc
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int SUM_W = (ADDR_W > 9) ? ADDR_W : 9;

  // Program store; contents survive reset and are loaded through the prog_* port.
  // INIT_HEX names an optional load image for flows that pre-initialise memories.
  logic [31:0] rom_mem [DEPTH];

  ifu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              in_flight_q, in_flight_d;
  logic [ADDR_W-1:0] in_flight_pc_q, in_flight_pc_d;
  logic [31:0]       rd_data_q, rd_data_d;

  logic [ADDR_W-1:0] q_head_pc;
  logic [31:0]       q_head_ir;
  logic [1:0]        q_count;

  logic              head_valid;
  logic              redirect;
  logic              pop;
  logic              push;
  logic              issue;
  logic [2:0]        pending;
  logic [ADDR_W-1:0] target;

  // Sequencing, read issue and redirect decisions for the coming edge
  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    in_flight_d    = 1'b0;
    in_flight_pc_d = in_flight_pc_q;
    rd_data_d      = rd_data_q;

    head_valid = (q_count != 2'd0);
    redirect   = branch_load && head_valid;
    pop        = head_valid && ir_ready && !redirect;
    push       = in_flight_q && !redirect;
    target     = ADDR_W'(SUM_W'(q_head_pc) + SUM_W'(branch_offset));

    // Words that will occupy the queue once the current in-flight read lands;
    // counting this cycle's pop keeps the pipe bubble-free while never overfilling.
    pending = {1'b0, q_count} - {2'b00, pop} + {2'b00, in_flight_q};

    // The flush cycle starts the target read itself, so the first target
    // word reaches the head two edges after the redirect.
    issue = ((state_q == S_RUN) || (state_q == S_FLUSH)) && !redirect && (pending < 3'd2);

    case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   state_d = redirect ? S_FLUSH : S_RUN;
      S_FLUSH: state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase

    if (redirect) begin
      fetch_pc_d = target;
    end else if (issue) begin
      fetch_pc_d     = fetch_pc_q + 1'b1;
      in_flight_d    = 1'b1;
      in_flight_pc_d = fetch_pc_q;
      rd_data_d      = rom_mem[fetch_pc_q];
    end
  end

  // Fetch state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_BOOT;
      fetch_pc_q     <= '0;
      in_flight_q    <= 1'b0;
      in_flight_pc_q <= '0;
      rd_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      fetch_pc_q     <= fetch_pc_d;
      in_flight_q    <= in_flight_d;
      in_flight_pc_q <= in_flight_pc_d;
      rd_data_q      <= rd_data_d;
    end
  end

  // Program load port; a read of the same address this cycle sees the old word
  always_ff @(posedge clk) begin
    if (prog_we) begin
      rom_mem[prog_addr] <= prog_data;
    end
  end

  ifu_queue #(
    .ADDR_W (ADDR_W)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .flush   (redirect),
    .push    (push),
    .push_pc (in_flight_pc_q),
    .push_ir (rd_data_q),
    .pop     (pop),
    .head_pc (q_head_pc),
    .head_ir (q_head_ir),
    .count   (q_count)
  );

  assign ir       = q_head_ir;
  assign ir_pc    = 32'(q_head_pc);
  assign ir_valid = head_valid;
  assign fetch_pc = 32'(fetch_pc_q);

endmodule : instr_fetch_unit
`default_nettype wire
